// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: one full-subtractor cell plus a borrow flop,
// processing LSB-first under a start/busy/done handshake.
module serial_subtractor #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         borrow
);

  localparam int unsigned CNT_W = $clog2(W) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [W-1:0]     sa;
  logic [W-1:0]     sb;
  logic [W-1:0]     res;
  logic             bq;
  logic [CNT_W-1:0] cnt;

  // Full-subtractor cell on the operand LSBs and the running borrow
  logic d_c;
  logic bo_c;
  assign d_c  = sa[0] ^ sb[0] ^ bq;
  assign bo_c = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bq);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      bq     <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        // DONE accepts a new request exactly like IDLE so back-to-back ops have no gap
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            res   <= '0;
            bq    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          res <= {d_c, res[W-1:1]};
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          bq  <= bo_c;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(W - 1)) begin
            diff   <= {d_c, res[W-1:1]};
            borrow <= bo_c;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: scoreboard of expected {borrow,diff}
// popped on every done pulse, plus per-cycle handshake checks.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;

  int total = 0;
  int bad   = 0;

  logic [W:0] exp_q[$];
  logic [W:0] last_res;

  serial_subtractor #(.W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] d;
    d = x - y;
    return {(x < y) ? 1'b1 : 1'b0, d};
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: got diff=%0d borrow=%0d, required no done", diff, borrow);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({borrow, diff} !== e) begin
          bad++;
          $display("FAIL result: got diff=%0d borrow=%0d, required diff=%0d borrow=%0d",
                   diff, borrow, e[W-1:0], e[W]);
        end
        last_res = e;
      end
    end
  end

  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int p1, input int p2);
    @(negedge clk);
    start = 1'b1;
    a = x;
    b = y;
    exp_q.push_back(model(x, y));
    for (int i = 1; i <= int'(W); i++) begin
      @(negedge clk);
      start = (i == p1 || i == p2) ? 1'b1 : 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      if (i == 1) begin
        total++;
        if ({borrow, diff} !== last_res) begin
          bad++;
          $display("FAIL held_result: got %0h, required %0h", {borrow, diff}, last_res);
        end
      end
      total++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL busy_phase: cycle %0d busy=%b done=%b, required busy=1 done=0", i, busy, done);
      end
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle: busy=%b done=%b, required busy=0 done=1", busy, done);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL after_done: busy=%b done=%b, required busy=0 done=0", busy, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    last_res = '0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b diff=%0d borrow=%b, required all 0",
               busy, done, diff, borrow);
    end
    rst_n = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    run_op(8'd100, 8'd37, 0, 0);
    run_op(8'd5, 8'd9, 0, 0);
    run_op(8'd0, 8'd1, 0, 0);
  endtask

  task automatic test_boundary();
    run_op(8'hFF, 8'hFF, 0, 0);
    run_op(8'h80, 8'h01, 0, 0);
    run_op(8'h00, 8'hFF, 0, 0);
  endtask

  task automatic test_ignore_start();
    run_op(8'd50, 8'd20, 3, 5);
    repeat (3) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        bad++;
        $display("FAIL ignored_start_queued: busy=%b done=%b, required 0 0", busy, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic eb;
    logic ed;
    @(negedge clk);
    start = 1'b1;
    a = 8'd10;
    b = 8'd3;
    exp_q.push_back(model(8'd10, 8'd3));
    @(negedge clk);
    a = 8'd3;
    b = 8'd10;
    exp_q.push_back(model(8'd3, 8'd10));
    for (int i = 1; i <= 2 * (int'(W) + 1); i++) begin
      if (i > 1) @(negedge clk);
      ed = (i == int'(W) + 1 || i == 2 * (int'(W) + 1)) ? 1'b1 : 1'b0;
      eb = ~ed;
      if (i == 2 * (int'(W) + 1)) start = 1'b0;
      total++;
      if (busy !== eb || done !== ed) begin
        bad++;
        $display("FAIL back_to_back: cycle %0d busy=%b done=%b, required busy=%b done=%b",
                 i, busy, done, eb, ed);
      end
    end
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL back_to_back_end: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1;
    a = 8'd1;
    b = 8'd2;
    exp_q.push_back(model(8'd1, 8'd2));
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: busy=%b done=%b diff=%0d borrow=%b, required all 0",
               busy, done, diff, borrow);
    end
    last_res = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 3) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || diff !== '0) begin
        bad++;
        $display("FAIL after_reset_mid: busy=%b done=%b diff=%0d, required 0 0 0", busy, done, diff);
      end
    end
    run_op(8'd200, 8'd55, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      run_op(W'($urandom), W'($urandom), 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundary();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    repeat (2) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_done: %0d results outstanding, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
